// File: rtl/font_arb_pkg.sv
// Shared constants for the font ROM arbiter: ROM geometry, painter ids, id width helper.
package font_arb_pkg;

  localparam int FONT_AW   = 11;  // {char_addr[6:0], row_addr[3:0]}
  localparam int FONT_DW   = 8;
  localparam int FONT_NREQ = 4;
  localparam int ID_W      = $clog2(FONT_NREQ);

  // Painter to requester-index mapping
  localparam int REQ_TITLE  = 0;
  localparam int REQ_TIMER  = 1;
  localparam int REQ_BOARD  = 2;
  localparam int REQ_STATUS = 3;

  // Width of a requester id; never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/font_rom_arbiter_rr_arbiter.sv
// Masked round-robin picker: combinational winner search from the pointer, registered pointer.
module rr_arbiter
  import font_arb_pkg::*;
#(
  parameter int NREQ = FONT_NREQ,
  parameter int IDW  = id_width(FONT_NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_eff,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  win_id,
  output logic            any
);

  logic [IDW-1:0] ptr;

  // Pick stage: first set request at or above ptr, wrapping to 0
  always_comb begin
    int idx;
    win    = '0;
    win_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!any && req_eff[idx]) begin
        win[idx] = 1'b1;
        win_id   = IDW'(idx);
        any      = 1'b1;
      end
    end
  end

  // Pointer stage: the slot after the winner becomes top priority; idle cycles keep it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (win_id == IDW'(NREQ - 1)) ? '0 : IDW'(win_id + 1'b1);
    end
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one font ROM among the text painters: round-robin grant, registered ROM address,
// and a ROM_LAT-deep valid/id pipeline that tags each returned font word with its requester.
module font_rom_arbiter
  import font_arb_pkg::*;
#(
  parameter int NREQ    = FONT_NREQ,
  parameter int AW      = FONT_AW,
  parameter int DW      = FONT_DW,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_data,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               busy
);

  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0] req_eff;
  logic [NREQ-1:0] win;
  logic [IDW-1:0]  win_id;
  logic            win_any;
  logic [IDW-1:0]  gnt_id_p0;
  logic [ROM_LAT-1:0] vld_p;
  logic [IDW-1:0]  id_p [ROM_LAT];

  // The requester granted last cycle is masked so it cannot be served twice for one request
  assign req_eff = req & ~gnt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_eff (req_eff),
    .win     (win),
    .win_id  (win_id),
    .any     (win_any)
  );

  // Grant stage p0: one-hot grant pulse and ROM address; address holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      rom_addr <= '0;
    end else begin
      gnt <= win;
      if (win_any) begin
        rom_addr <= req_addr[win_id*AW +: AW];
      end
    end
  end

  always_ff @(posedge clk) begin
    gnt_id_p0 <= win_id;
  end

  // ROM latency stages p1..pROM_LAT: valid bit (reset-cleared) travels with the requester id
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= |gnt;
      for (int k = 1; k < ROM_LAT; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    id_p[0] <= gnt_id_p0;
    for (int k = 1; k < ROM_LAT; k++) begin
      id_p[k] <= id_p[k-1];
    end
  end

  // Response stage: decode the arriving id to a one-hot valid alongside the ROM word
  always_comb begin
    rsp_valid = '0;
    if (vld_p[ROM_LAT-1]) begin
      rsp_valid[id_p[ROM_LAT-1]] = 1'b1;
    end
  end

  assign rsp_data = rom_data;
  assign busy     = (|gnt) | (|vld_p);

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter (NREQ=4, ROM_LAT=1) with a one-cycle font ROM model.
module tb_font_rom_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 11;
  localparam int DW   = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               busy;

  int checks = 0;
  int errors = 0;

  font_rom_arbiter #(
    .NREQ    (NREQ),
    .AW      (AW),
    .DW      (DW),
    .ROM_LAT (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] font(input logic [AW-1:0] a);
    return a[7:0] ^ {a[10:8], 5'h15};
  endfunction

  // Synchronous font ROM, one cycle latency
  always @(posedge clk) rom_data <= font(rom_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req   = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (gnt !== 4'b0000 || rsp_valid !== 4'b0000 || busy !== 1'b0 || rom_addr !== 11'h000) begin
      errors++;
      $display("FAIL reset_state gnt=%b rsp_valid=%b busy=%b rom_addr=%h required 0000/0000/0/000",
               gnt, rsp_valid, busy, rom_addr);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || rsp_valid !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle%0d gnt=%b rsp_valid=%b busy=%b required 0000/0000/0",
                 c, gnt, rsp_valid, busy);
      end
    end
  endtask

  task automatic test_single;
    do_reset();
    set_addr(0, 11'h541);
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL single_gnt got %b required 0001", gnt);
    end
    checks++;
    if (rom_addr !== 11'h541) begin
      errors++;
      $display("FAIL single_rom_addr got %h required 541", rom_addr);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got %b required 1", busy);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== font(11'h541)) begin
      errors++;
      $display("FAIL single_rsp got %b/%h required 0001/%h", rsp_valid, rsp_data, font(11'h541));
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL single_drain rsp_valid=%b busy=%b gnt=%b required 0000/0/0000",
               rsp_valid, busy, gnt);
    end
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] exp_g [5];
    logic [AW-1:0]   addrs [NREQ];
    int              idx [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    idx[0] = 0; idx[1] = 1; idx[2] = 2; idx[3] = 3; idx[4] = 0;
    addrs[0] = 11'h123; addrs[1] = 11'h2A7; addrs[2] = 11'h4F0; addrs[3] = 11'h7C9;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_addr(i, addrs[i]);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (gnt !== exp_g[k] || rom_addr !== addrs[idx[k]]) begin
        errors++;
        $display("FAIL rr_gnt%0d got %b/%h required %b/%h", k, gnt, rom_addr, exp_g[k], addrs[idx[k]]);
      end
      if (k > 0) begin
        checks++;
        if (rsp_valid !== exp_g[k-1] || rsp_data !== font(addrs[idx[k-1]])) begin
          errors++;
          $display("FAIL rr_rsp%0d got %b/%h required %b/%h", k-1, rsp_valid, rsp_data,
                   exp_g[k-1], font(addrs[idx[k-1]]));
        end
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (rsp_valid !== exp_g[4] || rsp_data !== font(addrs[0])) begin
      errors++;
      $display("FAIL rr_rsp4 got %b/%h required %b/%h", rsp_valid, rsp_data, exp_g[4], font(addrs[0]));
    end
    tick();
  endtask

  task automatic test_lone_requester;
    logic [NREQ-1:0] prev;
    do_reset();
    set_addr(2, 11'h3B5);
    req  = 4'b0100;
    prev = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (gnt !== ((k % 2 == 1) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL lone_gnt%0d got %b required %b", k, gnt, (k % 2 == 1) ? 4'b0100 : 4'b0000);
      end
      checks++;
      if ((gnt & prev) !== 4'b0000) begin
        errors++;
        $display("FAIL lone_back_to_back%0d got %b after %b required no repeat", k, gnt, prev);
      end
      prev = gnt;
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_withdrawal;
    do_reset();
    set_addr(0, 11'h011);
    set_addr(1, 11'h222);
    set_addr(3, 11'h633);
    req = 4'b0011;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL wd_first_gnt got %b required 0001", gnt);
    end
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000 || rom_addr !== 11'h633) begin
      errors++;
      $display("FAIL wd_gnt3 got %b/%h required 1000/633", gnt, rom_addr);
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== font(11'h011)) begin
      errors++;
      $display("FAIL wd_rsp0 got %b/%h required 0001/%h", rsp_valid, rsp_data, font(11'h011));
    end
    req = 4'b0000;
    tick();
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_data !== font(11'h633)) begin
      errors++;
      $display("FAIL wd_rsp3 got %b/%h required 1000/%h", rsp_valid, rsp_data, font(11'h633));
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0000 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL wd_no_rsp1 got rsp_valid=%b gnt=%b required 0000/0000", rsp_valid, gnt);
    end
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    set_addr(2, 11'h155);
    set_addr(3, 11'h766);
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL mid_gnt got %b required 0100", gnt);
    end
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_clear gnt=%b rsp_valid=%b busy=%b required 0000/0000/0", gnt, rsp_valid, busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_after_release%0d rsp_valid=%b busy=%b required 0000/0", c, rsp_valid, busy);
      end
    end
    req = 4'b1100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || rom_addr !== 11'h155) begin
      errors++;
      $display("FAIL mid_ptr_reset got %b/%h required 0100/155", gnt, rom_addr);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lone_requester();
    test_withdrawal();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
